// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin arbitration of N_REQ writeback requesters onto the
// single GPR write port, with a registered write stage and a per-register
// pending-write scoreboard used by decode for read-after-write hazard detection.
module gpr_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         rd_addr_0,
  input  logic [ADDR_W-1:0]         rd_addr_1,
  output logic                      hazard_0,
  output logic                      hazard_1,
  input  logic                      flush,
  output logic                      gpr_we,
  output logic [ADDR_W-1:0]         gpr_wr_addr,
  output logic [DATA_W-1:0]         gpr_wr_data
);

  localparam int N_REGS = 1 << ADDR_W;
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [N_REQ-1:0]  grant;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  int                scan_idx;

  // Scan requesters starting at the rr pointer; the first valid one wins.
  always_comb begin
    grant     = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    win_data  = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(rr_ptr_reg) + k) % N_REQ;
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan_idx);
        win_addr  = req_addr[scan_idx*ADDR_W +: ADDR_W];
        win_data  = req_data[scan_idx*DATA_W +: DATA_W];
      end
    end
    if (win_found) begin
      grant[win_idx] = 1'b1;
    end
  end

  // The write stage never stalls, so the grant is the accept.
  assign req_ready = grant;

  // ---------------------------------------------------------------------------
  // Registered write stage
  // ---------------------------------------------------------------------------
  logic              gpr_we_reg;
  logic [ADDR_W-1:0] gpr_wr_addr_reg;
  logic [DATA_W-1:0] gpr_wr_data_reg;

  // Capture the winner into the write port and advance the pointer past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_we_reg      <= 1'b0;
      gpr_wr_addr_reg <= '0;
      gpr_wr_data_reg <= '0;
      rr_ptr_reg      <= '0;
    end else if (win_found) begin
      gpr_we_reg      <= 1'b1;
      gpr_wr_addr_reg <= win_addr;
      gpr_wr_data_reg <= win_data;
      rr_ptr_reg      <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end else begin
      gpr_we_reg      <= 1'b0;
    end
  end

  assign gpr_we      = gpr_we_reg;
  assign gpr_wr_addr = gpr_wr_addr_reg;
  assign gpr_wr_data = gpr_wr_data_reg;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_vec [N_REGS];
  logic             issue_dec;
  logic             issue_fire;

  // A write retiring to issue_addr this cycle frees a slot even if the counter is full.
  assign issue_dec   = gpr_we_reg && (gpr_wr_addr_reg == issue_addr);
  assign issue_ready = !((cnt_vec[issue_addr] == CNT_MAX) && !issue_dec);
  assign issue_fire  = issue_valid && issue_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic             inc_hit;
      logic             dec_hit;

      assign inc_hit = issue_fire && (issue_addr == ADDR_W'(gi));
      assign dec_hit = gpr_we_reg && (gpr_wr_addr_reg == ADDR_W'(gi));

      // Count outstanding writes; flush clears, simultaneous inc/dec cancel,
      // and a stray decrement of an empty counter saturates at zero.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          cnt_reg <= '0;
        end else if (inc_hit && !dec_hit) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end else if (dec_hit && !inc_hit && (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - CNT_ONE;
        end
      end

      assign cnt_vec[gi] = cnt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Hazard detection with write-to-read bypass for the last outstanding write
  // ---------------------------------------------------------------------------
  assign hazard_0 = (cnt_vec[rd_addr_0] != '0) &&
                    !(gpr_we_reg && (gpr_wr_addr_reg == rd_addr_0) && (cnt_vec[rd_addr_0] == CNT_ONE));
  assign hazard_1 = (cnt_vec[rd_addr_1] != '0) &&
                    !(gpr_we_reg && (gpr_wr_addr_reg == rd_addr_1) && (cnt_vec[rd_addr_1] == CNT_ONE));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed steps from the test plan followed by a randomized
// phase, all checked against a behavioural model of the write port and scoreboard.
module tb_gpr_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic            issue_ready;
  logic [AW-1:0]   rd_addr_0, rd_addr_1;
  logic            hazard_0, hazard_1;
  logic            flush;
  logic            gpr_we;
  logic [AW-1:0]   gpr_wr_addr;
  logic [DW-1:0]   gpr_wr_data;

  gpr_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .hazard_0(hazard_0), .hazard_1(hazard_1),
    .flush(flush), .gpr_we(gpr_we), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Requester-side pending writes (held until accepted)
  bit            p_valid [N];
  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_data  [N];

  // Behavioural model: outstanding writes per register, write port, fairness pointer
  int            m_cnt [NR];
  int            m_ptr;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Values observed during the last cycle, for directed checks
  int            last_g;
  logic          obs_ir, obs_h0, obs_h1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hazard(input logic [AW-1:0] a);
    return (m_cnt[a] != 0) && !(m_we && m_addr == a && m_cnt[a] == 1);
  endfunction

  // One clock: drive inputs, check combinational outputs, step model, check write port.
  task automatic cycle();
    int            g;
    logic [N-1:0]  exp_ready;
    bit            exp_ir;
    bit            inc, dec;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = p_valid[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_data[i*DW +: DW]   = p_data[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && p_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_ir = !(m_cnt[issue_addr] == 3 && !(m_we && m_addr == issue_addr));
    obs_ir = issue_ready; obs_h0 = hazard_0; obs_h1 = hazard_1;
    if (!rst) begin
      chk("req_ready",   req_ready,   exp_ready);
      chk("issue_ready", issue_ready, exp_ir);
      chk("hazard_0",    hazard_0,    m_hazard(rd_addr_0));
      chk("hazard_1",    hazard_1,    m_hazard(rd_addr_1));
    end
    last_g = rst ? -1 : g;
    inc = issue_valid && exp_ir;
    dec = m_we;
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_we = 0; m_addr = '0; m_data = '0; m_ptr = 0;
    end else begin
      if (flush) begin
        foreach (m_cnt[r]) m_cnt[r] = 0;
      end else if (!(inc && dec && issue_addr == m_addr)) begin
        if (dec && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
        if (inc) m_cnt[issue_addr]++;
      end
      if (g >= 0) begin
        m_we = 1; m_addr = p_addr[g]; m_data = p_data[g]; m_ptr = (g + 1) % N;
        p_valid[g] = 0;
      end else begin
        m_we = 0;
      end
    end
    chk("gpr_we",      gpr_we,      m_we);
    chk("gpr_wr_addr", gpr_wr_addr, m_addr);
    chk("gpr_wr_data", gpr_wr_data, m_data);
    $display("t=%0t rst=%0b g=%0d iss=%0b/%0d fl=%0b we=%0b wa=%0d wd=%08h h=%0b%0b",
             $time, rst, last_g, issue_valid, issue_addr, flush, gpr_we, gpr_wr_addr,
             gpr_wr_data, obs_h0, obs_h1);
  endtask

  task automatic quiet();
    rst = 0; flush = 0; issue_valid = 0;
  endtask

  initial begin
    rst = 1; flush = 0; issue_valid = 0; issue_addr = '0;
    rd_addr_0 = '0; rd_addr_1 = '0;
    req_valid = '0; req_addr = '0; req_data = '0;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0;
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1; p_addr[i] = AW'(i + 1); p_data[i] = DW'(32'h100 + i);
    end
    @(posedge clk); #1;

    // Reset held two cycles with all requesters valid
    cycle(); cycle();
    chk("rst_we", gpr_we, 1'b0);
    chk("rst_addr", gpr_wr_addr, '0);
    quiet();

    // Round-robin with all three continuously valid
    for (int s = 0; s < 4; s++) begin
      cycle();
      chk("rr_grant", last_g, s % N);
      chk("rr_we", gpr_we, 1'b1);
      p_valid[last_g] = 1;
    end
    foreach (p_valid[i]) p_valid[i] = 0;
    cycle();

    // Single write
    p_valid[0] = 1; p_addr[0] = 5'd7; p_data[0] = 32'hDEADBEEF;
    cycle();
    chk("single_we", gpr_we, 1'b1);
    chk("single_addr", gpr_wr_addr, 5'd7);
    chk("single_data", gpr_wr_data, 32'hDEADBEEF);
    cycle();
    chk("single_we_off", gpr_we, 1'b0);

    // Scoreboard hazard and bypass on register 9
    rd_addr_0 = 5'd9; rd_addr_1 = 5'd0;
    issue_valid = 1; issue_addr = 5'd9;
    cycle();
    issue_valid = 0;
    p_valid[1] = 1; p_addr[1] = 5'd9; p_data[1] = 32'h0000_0909;
    cycle();
    chk("sb_hazard", obs_h0, 1'b1);
    cycle();
    chk("sb_bypass", obs_h0, 1'b0);
    cycle();
    chk("sb_cleared", obs_h0, 1'b0);

    // Saturation on register 4, then issue alongside a retiring write
    rd_addr_0 = 5'd4;
    issue_valid = 1; issue_addr = 5'd4;
    cycle(); cycle(); cycle();
    cycle();
    chk("sat_ready", obs_ir, 1'b0);
    issue_valid = 0;
    p_valid[0] = 1; p_addr[0] = 5'd4; p_data[0] = 32'h4444_0004;
    cycle();
    issue_valid = 1;
    cycle();
    chk("sat_simul_ready", obs_ir, 1'b1);
    cycle();
    chk("sat_still_full", obs_ir, 1'b0);
    issue_valid = 0;

    // Flush while a write to register 12 is in the write stage
    rd_addr_1 = 5'd12;
    issue_valid = 1; issue_addr = 5'd12;
    cycle(); cycle();
    issue_valid = 0;
    p_valid[2] = 1; p_addr[2] = 5'd12; p_data[2] = 32'hC0C0_1212;
    cycle();
    chk("flush_wr_we", gpr_we, 1'b1);
    chk("flush_wr_addr", gpr_wr_addr, 5'd12);
    flush = 1;
    cycle();
    chk("flush_hazard_before", obs_h1, 1'b1);
    flush = 0;
    cycle();
    chk("flush_hazard_after", obs_h1, 1'b0);
    rd_addr_0 = 5'd4;
    cycle();
    chk("flush_cnt4_clear", obs_h0, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && ($urandom % 3 == 0)) begin
          p_valid[i] = 1;
          p_addr[i]  = AW'($urandom % 8);
          p_data[i]  = $urandom;
        end
      end
      issue_valid = ($urandom % 2 == 0);
      issue_addr  = AW'($urandom % 8);
      rd_addr_0   = AW'($urandom % 8);
      rd_addr_1   = AW'(($urandom % 16 == 0) ? $urandom % NR : $urandom % 8);
      flush       = ($urandom % 50 == 0);
      rst         = ($urandom % 300 == 0);
      cycle();
    end
    quiet();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
